// File: rtl/i2c_slave_target.sv
// I2C slave target: answers to one 7-bit address, receives write bytes and
// returns read bytes from a host-supplied data port.
//
// Ports:
//   clk       system clock (at least 8x scl); all logic on its rising edge
//   reset     synchronous, active-high reset
//   scl_in    serial clock sampled from the pad
//   sda_in    serial data sampled from the pad
//   sda_oe    1 = pull sda low, 0 = release (open drain)
//   rx_data   last byte written by the master
//   rx_valid  one-clk pulse marking rx_data as new
//   tx_data   byte to return on a master read, captured while tx_req is high
//   tx_req    one-clk pulse; tx_data is loaded into the shifter at that edge
//   busy      high from an address-matched START until the next STOP/START
module i2c_slave_target #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck,
        StIgnore
    } state_e;

    // Synchronizers plus one extra registered copy for edge detection.
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    // Set on the scl rise of an acknowledge bit, so the following scl fall
    // is known to end that bit rather than to start it.
    logic       ack_seen_q, ack_seen_d;
    logic       tx_req_c;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // scl must be high in both samples so an sda edge during an scl edge
    // is never mistaken for START/STOP.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            ack_seen_q <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;
        ack_seen_d = ack_seen_q;
        tx_req_c   = 1'b0;

        if (start_det) begin
            // Also covers repeated START: any partial byte is dropped.
            state_d    = StAddr;
            bit_cnt_d  = 3'd0;
            shift_d    = 8'h00;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ack_seen_d = 1'b0;
        end else if (stop_det) begin
            state_d    = StIdle;
            bit_cnt_d  = 3'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ack_seen_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sda_oe_d = 1'b0;
                end

                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // shift_q[6:0] holds the 7 address bits; sda_s is R/W.
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                state_d    = StAddrAck;
                                rw_d       = sda_s;
                                busy_d     = 1'b1;
                                ack_seen_d = 1'b0;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end

                StAddrAck: begin
                    if (scl_fall) begin
                        if (!ack_seen_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            ack_seen_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            if (rw_q) begin
                                tx_req_c = 1'b1;
                                shift_d  = tx_data;
                                sda_oe_d = ~tx_data[7];
                                state_d  = StRead;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = StWrite;
                            end
                        end
                    end else if (scl_rise) begin
                        ack_seen_d = 1'b1;
                    end
                end

                StWrite: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            ack_seen_d = 1'b0;
                            state_d    = StWriteAck;
                        end
                    end
                end

                StWriteAck: begin
                    if (scl_fall) begin
                        if (!ack_seen_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d   = 1'b0;
                            ack_seen_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            state_d    = StWrite;
                        end
                    end else if (scl_rise) begin
                        ack_seen_d = 1'b1;
                    end
                end

                StRead: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_seen_d = 1'b0;
                            state_d    = StReadAck;
                        end
                    end else if (scl_fall) begin
                        // Present the next bit; shift_q[7] is the bit just sent.
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end

                StReadAck: begin
                    if (scl_fall) begin
                        if (!ack_seen_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            tx_req_c   = 1'b1;
                            shift_d    = tx_data;
                            sda_oe_d   = ~tx_data[7];
                            ack_seen_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            state_d    = StRead;
                        end
                    end else if (scl_rise) begin
                        if (sda_s) begin
                            state_d = StIgnore;
                        end else begin
                            ack_seen_d = 1'b1;
                        end
                    end
                end

                StIgnore: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_c;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bus-functional I2C master drives scl/sda,
// a transaction-level model predicts ACKs, received bytes, read data and
// tx_req counts, and a monitor scoreboards every rx_valid pulse.
module tb_i2c_slave_target;

    localparam logic [6:0] SA = 7'h50;
    localparam int         Q  = 8;  // clk cycles per quarter scl period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;

    int         checks = 0;
    int         failures = 0;
    int         tx_req_cnt = 0;
    logic       oe_seen = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] txn_q[$];

    // Wired-AND bus: master and target can only pull low.
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_target #(
        .SLAVE_ADDR (SA),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scl_in  (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every rx_valid, counts tx_req pulses.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (sda_oe) oe_seen = 1'b1;
            if (tx_req) tx_req_cnt++;
            if (rx_valid) begin
                checks++;
                if (exp_rx.size() == 0) begin
                    failures++;
                    $display("FAIL rx_unexpected actual=%02h required=no_pulse", rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    if (rx_data !== e) begin
                        failures++;
                        $display("FAIL rx_data actual=%02h required=%02h", rx_data, e);
                    end
                end
            end
        end
    end

    task automatic qwait();
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl = 1'b1;   qwait();
        sda_m = 1'b0; qwait();
        scl = 1'b0;   qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl = 1'b1;   qwait();
        sda_m = 1'b1; qwait();
        qwait();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;  qwait();
        scl = 1'b1; qwait(); qwait();
        scl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qwait();
        scl = 1'b1;   qwait();
        b = sda_line; qwait();
        scl = 1'b0;   qwait();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic nack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(nack);
    endtask

    // next_tx is presented once the current byte has surely been captured.
    task automatic recv_byte(output logic [7:0] v, input logic nack, input logic [7:0] next_tx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
            if (i == 7) tx_data = next_tx;
        end
        write_bit(nack);
    endtask

    // Write transaction of the bytes in txn_q.
    task automatic write_txn(input logic [7:0] addr);
        logic nack, match;
        match = (addr[7:1] == SA);
        bus_start();
        send_byte(addr, nack);
        check("addr_ack", 32'(nack), 32'(!match));
        check("busy_addr", 32'(busy), 32'(match));
        for (int k = 0; k < txn_q.size(); k++) begin
            if (match) exp_rx.push_back(txn_q[k]);
            send_byte(txn_q[k], nack);
            check("data_ack", 32'(nack), 32'(!match));
            check("rx_drain", 32'(exp_rx.size()), 32'd0);
        end
        bus_stop();
        check("busy_stop", 32'(busy), 32'd0);
        if (match && txn_q.size() > 0)
            check("rx_hold", 32'(rx_data), 32'(txn_q[txn_q.size()-1]));
    endtask

    // Read transaction returning the bytes in txn_q; master NACKs the last.
    task automatic read_txn(input logic [7:0] addr);
        logic       nack, match;
        logic [7:0] v, nxt;
        int         base;
        match = (addr[7:1] == SA);
        base = tx_req_cnt;
        tx_data = txn_q[0];
        bus_start();
        send_byte(addr, nack);
        check("addr_ack", 32'(nack), 32'(!match));
        check("busy_addr", 32'(busy), 32'(match));
        for (int k = 0; k < txn_q.size(); k++) begin
            nxt = (k + 1 < txn_q.size()) ? txn_q[k+1] : 8'h00;
            recv_byte(v, (k == txn_q.size() - 1), nxt);
            check("read_byte", 32'(v), match ? 32'(txn_q[k]) : 32'hFF);
        end
        check("busy_ignore", 32'(busy), 32'(match));
        check("oe_ignore", 32'(sda_oe), 32'd0);
        bus_stop();
        check("busy_stop", 32'(busy), 32'd0);
        check("tx_req_count", 32'(tx_req_cnt - base), match ? 32'(txn_q.size()) : 32'd0);
    endtask

    initial begin
        logic       nack;
        logic [7:0] v;
        int         base;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        qwait();

        // Basic write.
        txn_q = '{8'h3C};
        write_txn(8'hA0);

        // Single-byte read, master NACK.
        txn_q = '{8'h96};
        read_txn(8'hA1);

        // Wrong address: target must never pull sda.
        oe_seen = 1'b0;
        txn_q = '{8'($urandom)};
        write_txn(8'hA2);
        check("nomatch_oe", 32'(oe_seen), 32'd0);

        // General call is not this target.
        oe_seen = 1'b0;
        txn_q = '{8'h12};
        write_txn(8'h00);
        check("gcall_oe", 32'(oe_seen), 32'd0);

        // Repeated START after a partial write byte.
        base = tx_req_cnt;
        tx_data = 8'hC3;
        bus_start();
        send_byte(8'hA0, nack);
        check("rs_addr_w_ack", 32'(nack), 32'd0);
        for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
        bus_start();
        send_byte(8'hA1, nack);
        check("rs_addr_r_ack", 32'(nack), 32'd0);
        recv_byte(v, 1'b1, 8'h00);
        check("rs_read", 32'(v), 32'hC3);
        bus_stop();
        check("rs_tx_req", 32'(tx_req_cnt - base), 32'd1);
        check("rs_rx_hold", 32'(rx_data), 32'h3C);

        // Two-byte read with master ACK on the first.
        txn_q = '{8'h11, 8'h22};
        read_txn(8'hA1);

        // Reset while the target drives the write ACK.
        bus_start();
        send_byte(8'hA0, nack);
        check("wr_addr_ack", 32'(nack), 32'd0);
        exp_rx.push_back(8'h5A);
        v = 8'h5A;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        check("wack_driven", 32'(sda_oe), 32'd1);
        check("wack_rx_drain", 32'(exp_rx.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", 32'(sda_oe), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_rx_clear", 32'(rx_data), 32'h00);
        check("rst_busy_clear", 32'(busy), 32'd0);
        sda_m = 1'b1; qwait();
        scl = 1'b1;   qwait();
        txn_q = '{8'h55};
        write_txn(8'hA0);

        // Randomized transactions.
        for (int t = 0; t < 10; t++) begin
            logic [6:0] a;
            logic       rw;
            int         n;
            a = ($urandom_range(0, 3) != 0) ? SA : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            txn_q.delete();
            for (int k = 0; k < n; k++) txn_q.push_back(8'($urandom));
            if (rw) read_txn({a, 1'b1});
            else    write_txn({a, 1'b0});
        end

        qwait();
        check("final_rx_drain", 32'(exp_rx.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave_target.md
I2C_SLAVE_TARGET -- requirements
Module: i2c_slave_target

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, is the 7-bit bus address this target answers to.
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops on scl_in and sda_in (legal range 2..3).
REQ-003 clk  input  1  is the system clock; it runs at least 8x faster than scl and all logic is clocked on its rising edge.
REQ-004 reset  input  1  is a synchronous, active-high reset.
REQ-005 scl_in  input  1  is the serial clock as sampled from the bus pad.
REQ-006 sda_in  input  1  is the serial data as sampled from the bus pad.
REQ-007 sda_oe  output  1  when high, the pad pulls sda low; when low, sda is released (open-drain, never driven high).
REQ-008 rx_data  output  8  holds the last byte written by the master.
REQ-009 rx_valid  output  1  is a one-clk pulse marking rx_data as new.
REQ-010 tx_data  input  8  is the byte to return on a master read; it is sampled on tx_req.
REQ-011 tx_req  output  1  is a one-clk pulse on which tx_data is captured into the shift register.
REQ-012 busy  output  1  is high from an address-matched START until the next STOP or START.

Function
REQ-013 scl_in and sda_in shall pass through SYNC_STAGES flops before use.
REQ-014 Edge detection shall use one further registered copy of each synchronized signal.
REQ-015 START is sda falling while scl is high; STOP is sda rising while scl is high.
REQ-016 Data shall be sampled on the scl rising edge and sda_oe shall change only on the scl falling edge (one clk after it is detected).
REQ-017 The state machine shall have the states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK and IGNORE.
  - IDLE: a START moves to ADDR.
  - ADDR: shift 8 bits MSB first into a shift register; a 3-bit bit counter counts 0..7 and wraps.
  - After the 8th bit, if addr[7:1]==SLAVE_ADDR go to ADDR_ACK, else go to IGNORE.
  - ADDR_ACK: hold sda_oe=1 for the ninth scl low/high period.
  - Leaving ADDR_ACK with R/W=0 goes to WRITE.
  - Leaving ADDR_ACK with R/W=1 pulses tx_req, loads tx_data and goes to READ.
  - WRITE: after 8 bits, update rx_data, pulse rx_valid once and go to WRITE_ACK (drive ACK, sda_oe=1), then back to WRITE.
  - READ: sda_oe = ~shift[7] per bit, MSB first; after 8 bits release sda and go to READ_ACK to sample the master's bit.
  - READ_ACK with ACK (0): pulse tx_req, reload and return to READ.
  - READ_ACK with NACK (1): go to IGNORE.
  - IGNORE: keep sda_oe=0 and wait.
REQ-018 A STOP in any state shall go to IDLE with sda_oe=0 and the bit counter cleared.
REQ-019 A START in any state, including a repeated START mid-byte, shall go to ADDR with the bit counter cleared and any partial byte discarded (no rx_valid).
REQ-020 If STOP/START detection and an scl edge occur in the same clk, the START/STOP takes priority.
REQ-021 The general call address 7'h00 shall not match unless SLAVE_ADDR==7'h00.
REQ-022 rx_valid and tx_req shall each be exactly one clk wide; rx_data shall hold its value until the next completed write byte.
REQ-023 Latency: rx_valid shall assert 1 clk after the synchronized scl rising edge of bit 8 of a write byte.

Reset
REQ-024 While reset is high on a rising clk edge, the following shall hold:
  - state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0;
  - bit counter=0 and shift register=8'h00;
  - synchronizer and edge flops set to 1 (bus idle).
REQ-025 A reset asserted mid-transfer shall release sda within 1 clk of the reset edge.
REQ-026 After reset, the target shall ignore bus activity until the next START.

Verification
REQ-027 Write 0xA0 (addr 0x50, W) then 0x3C, then STOP -> ACK after each byte; rx_data=0x3C; rx_valid pulses once; busy falls at STOP.
REQ-028 Read 0xA1 with tx_data=0x96, master NACK -> sda carries 1,0,0,1,0,1,1,0; tx_req pulses once; state=IGNORE then IDLE at STOP.
REQ-029 Address 0xA2 (0x51) -> no ACK (sda_oe stays 0 for all 9 bits); busy=0; no rx_valid.
REQ-030 Write 0xA0, 4 data bits, then repeated START and 0xA1 -> no rx_valid; ACK on the read address; tx_req pulses.
REQ-031 Reset asserted during WRITE_ACK -> sda_oe=0 on the next clk; rx_data=0x00; a following full write of 0x55 is received correctly.
REQ-032 Two-byte read (0x11, 0x22) with master ACK on the first byte -> tx_req pulses twice; the serialized bytes match.
